instruction_encoder_stream: RTL

INSTRUCTION_ENCODER_STREAM -- requirements
Module: instruction_encoder_stream

---
 rtl/instruction_encoder_stream.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/instruction_encoder_stream.sv
// instruction_encoder_stream
// Packs one instruction field set per handshake into 16-bit halfwords for a
// program-memory writer. A short instruction is one halfword; an extended one
// is a high halfword followed by a low halfword carrying the full immediate.
// Each emitted halfword is tagged with a running 8-bit word address.
//
// Optional feature macro: AUTO_EXTEND_EN
//   When defined, an immediate that does not fit in 6 bits forces the
//   extended format, so trunc_err can never set.
//
// Handshake rule (both ports): a transfer happens on the rising edge where
// valid and ready are both high; valid never depends on ready, and the payload
// of a presented halfword is held unchanged until it is taken.
module instruction_encoder_stream (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  opcode,
    input  logic [2:0]  reg1,
    input  logic [2:0]  reg2,
    input  logic [15:0] immediate_16,
    input  logic        use_extended,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [7:0]  out_addr,
    output logic        out_last,
    input  logic        addr_load,
    input  logic [7:0]  addr_value,
    output logic        trunc_err,
    output logic        wrap_flag
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        EXT_HI = 2'd2,
        EXT_LO = 2'd3
    } state_t;

    // Registered FSM state; kept as a named enum so checkers can bind to it.
    state_t      state;
    state_t      state_nxt;

    logic [15:0] lo_data;       // low halfword waiting behind EXT_HI
    logic        single_trunc;  // pending short word drops immediate bits
    logic        ext_sel;
    logic        imm_wide;
    logic        accept;
    logic        fire;

    assign imm_wide = |immediate_16[15:6];

`ifdef AUTO_EXTEND_EN
    assign ext_sel = use_extended | imm_wide;
`else
    assign ext_sel = use_extended;
`endif

    assign out_valid = (state != IDLE);
    assign out_last  = (state == SINGLE) || (state == EXT_LO);
    assign fire      = out_valid & out_ready;
    // A new field set can be taken while the final halfword of the previous
    // instruction leaves, which keeps short instructions at one per cycle.
    assign in_ready  = (state == IDLE) | (fire & out_last);
    assign accept    = in_valid & in_ready;

    // State register; reset abandons any half-emitted extended instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = ext_sel ? EXT_HI : SINGLE;
                end
            end
            EXT_HI: begin
                if (out_ready) begin
                    state_nxt = EXT_LO;
                end
            end
            SINGLE, EXT_LO: begin
                if (out_ready) begin
                    if (accept) begin
                        state_nxt = ext_sel ? EXT_HI : SINGLE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Halfword datapath: build words on acceptance, swap in the low half
    // once the high half has been taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data     <= 16'h0000;
            lo_data      <= 16'h0000;
            single_trunc <= 1'b0;
        end else if (accept) begin
            if (ext_sel) begin
                out_data <= {opcode, reg1, reg2, 6'b000000};
            end else begin
                out_data <= {opcode, reg1, reg2, immediate_16[5:0]};
            end
            lo_data      <= immediate_16;
            single_trunc <= ~ext_sel & imm_wide;
        end else if (fire && (state == EXT_HI)) begin
            out_data <= lo_data;
        end
    end

    // Word address counter and sticky status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_addr  <= 8'h00;
            trunc_err <= 1'b0;
            wrap_flag <= 1'b0;
        end else if ((state == IDLE) && addr_load) begin
            out_addr <= addr_value;
        end else if (fire) begin
            out_addr <= out_addr + 8'd1;
            if (out_addr == 8'hFF) begin
                wrap_flag <= 1'b1;
            end
            if ((state == SINGLE) && single_trunc) begin
                trunc_err <= 1'b1;
            end
        end
    end

endmodule
